// File: rtl/irq_controller.sv
// Interrupt controller: latches rising-edge interrupt pulses into pending bits, masks
// them with a software enable, and exposes PENDING/ENABLE/CLAIM/OVERRUN over a 4-word window.
module irq_controller #(
  parameter int unsigned NSRC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic [1:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            rd,
  output logic [31:0]     spo,
  output logic            ready,
  output logic            irq_out
);

  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 4;
  localparam int unsigned PADW = DW - IDW - 1;

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_EN    = 2'd1;
  localparam logic [1:0] A_CLAIM = 2'd2;
  localparam logic [1:0] A_OVR   = 2'd3;

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] overrun;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] qual;
  logic [NSRC-1:0] claim_oh;
  logic [IDW-1:0]  claim_id;
  logic            claim_hit;
  logic            rd_acc;
  logic            claim_take;
  logic [NSRC-1:0] wdata;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] ovr_set;
  logic [NSRC-1:0] ovr_clr;
  logic [DW-1:0]   rdata;

  // Data bits above the source count have no storage behind them.
  logic unused_d_hi;
  assign unused_d_hi = ^d[DW-1:NSRC];

  assign wdata = d[NSRC-1:0];
  assign rise  = src & ~src_q;
  assign qual  = pending & enable;
  // A simultaneous write takes priority; the read is dropped.
  assign rd_acc = rd & ~we;

  // Lowest-index qualifying source wins the claim.
  always_comb begin
    claim_oh  = qual & (~qual + NSRC'(1));
    claim_hit = |qual;
    claim_id  = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (claim_oh[i]) claim_id = IDW'(i);
    end
  end

  assign claim_take = rd_acc && (a == A_CLAIM) && claim_hit;

  always_comb begin
    pend_clr = '0;
    ovr_clr  = '0;
    if (we && (a == A_PEND)) pend_clr = wdata;
    if (claim_take)          pend_clr = pend_clr | claim_oh;
    if (we && (a == A_OVR))  ovr_clr  = wdata;
  end

  // A pulse lost only if the bit stays pending through this cycle.
  assign ovr_set = rise & pending & ~pend_clr;

  always_comb begin
    rdata = '0;
    case (a)
      A_PEND:  rdata = DW'(pending);
      A_EN:    rdata = DW'(enable);
      A_CLAIM: rdata = claim_hit ? {1'b1, PADW'(0), claim_id} : '0;
      A_OVR:   rdata = DW'(overrun);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q   <= '0;
      pending <= '0;
      enable  <= '0;
      overrun <= '0;
      spo     <= '0;
      ready   <= 1'b0;
      irq_out <= 1'b0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~pend_clr) | rise;
      overrun <= (overrun & ~ovr_clr) | ovr_set;
      if (we && (a == A_EN)) enable <= wdata;
      ready   <= we | rd;
      if (rd_acc) spo <= rdata;
      irq_out <= |qual;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: requests push expected responses,
// a negedge monitor pops and checks them on each ready pulse.
module tb_irq_controller;

  localparam int unsigned NSRC = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NSRC-1:0] src = '0;
  logic [1:0]      a   = '0;
  logic [31:0]     d   = '0;
  logic            we  = 1'b0;
  logic            rd  = 1'b0;
  logic [31:0]     spo;
  logic            ready;
  logic            irq_out;

  irq_controller #(.NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .src(src), .a(a), .d(d), .we(we), .rd(rd),
    .spo(spo), .ready(ready), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q_data[$];
  bit          q_chk[$];
  int          q_cyc[$];
  string       q_name[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request.
  int          m_cyc;
  logic [31:0] m_data;
  bit          m_chk;
  string       m_name;
  always @(negedge clk) begin
    if (rst && ready) begin
      if (q_cyc.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        m_cyc  = q_cyc.pop_front();
        m_data = q_data.pop_front();
        m_chk  = q_chk.pop_front();
        m_name = q_name.pop_front();
        check({m_name, "_cycle"}, 32'(cyc), 32'(m_cyc));
        if (m_chk) check(m_name, spo, m_data);
      end
    end
  end

  task automatic push_exp(input logic [31:0] data, input bit chk, input string name);
    q_data.push_back(data);
    q_chk.push_back(chk);
    q_cyc.push_back(cyc + 1);
    q_name.push_back(name);
  endtask

  task automatic do_rd(input logic [1:0] addr, input logic [31:0] exp, input string name);
    @(negedge clk);
    a = addr; rd = 1'b1; we = 1'b0;
    push_exp(exp, 1'b1, name);
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic do_wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    a = addr; d = data; we = 1'b1; rd = 1'b0;
    push_exp(32'd0, 1'b0, "write");
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic pulse(input logic [NSRC-1:0] mask);
    @(negedge clk);
    src = mask;
    @(posedge clk); #1;
    src = '0;
  endtask

  task automatic claim_with_src(input logic [NSRC-1:0] mask, input logic [31:0] exp, input string name);
    @(negedge clk);
    src = mask; a = 2'd2; rd = 1'b1; we = 1'b0;
    push_exp(exp, 1'b1, name);
    @(posedge clk); #1;
    src = '0; rd = 1'b0;
  endtask

  task automatic wr_with_src(input logic [1:0] addr, input logic [31:0] data, input logic [NSRC-1:0] mask);
    @(negedge clk);
    src = mask; a = addr; d = data; we = 1'b1; rd = 1'b0;
    push_exp(32'd0, 1'b0, "write");
    @(posedge clk); #1;
    src = '0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset and idle reads
    repeat (3) @(negedge clk);
    check("rst_spo", spo, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_irq", 32'(irq_out), 32'd0);
    rst = 1'b1;
    do_rd(2'd0, 32'h0, "idle_pend");
    do_rd(2'd1, 32'h0, "idle_en");
    do_rd(2'd2, 32'h0, "idle_claim");
    do_rd(2'd3, 32'h0, "idle_ovr");

    // Timer path
    do_wr(2'd1, 32'h1);
    pulse(4'h1);
    @(negedge clk);
    check("timer_irq_t1", 32'(irq_out), 32'd0);
    @(negedge clk);
    check("timer_irq_t2", 32'(irq_out), 32'd1);
    do_rd(2'd0, 32'h1, "timer_pend");
    do_rd(2'd2, 32'h8000_0000, "timer_claim");
    @(negedge clk);
    check("timer_irq_claim_n1", 32'(irq_out), 32'd1);
    @(negedge clk);
    check("timer_irq_claim_n2", 32'(irq_out), 32'd0);
    do_rd(2'd2, 32'h0, "timer_claim2");

    // Priority and mask
    do_wr(2'd1, 32'h6);
    pulse(4'hF);
    idle(2);
    check("prio_irq", 32'(irq_out), 32'd1);
    do_rd(2'd0, 32'hF, "prio_pend");
    do_rd(2'd2, 32'h8000_0001, "prio_claim1");
    do_rd(2'd2, 32'h8000_0002, "prio_claim2");
    do_rd(2'd2, 32'h0, "prio_claim_none");
    do_rd(2'd0, 32'h9, "prio_pend_end");
    idle(2);
    check("prio_irq_end", 32'(irq_out), 32'd0);

    // Overrun
    do_wr(2'd0, 32'hF);
    do_rd(2'd0, 32'h0, "ovr_pend_clr");
    pulse(4'h1);
    idle(5);
    pulse(4'h1);
    do_rd(2'd3, 32'h1, "ovr_set");
    do_wr(2'd3, 32'h1);
    do_rd(2'd3, 32'h0, "ovr_w1c");
    do_wr(2'd1, 32'h1);
    claim_with_src(4'h1, 32'h8000_0000, "ovr_claim_race");
    do_rd(2'd0, 32'h1, "ovr_race_pend");
    do_rd(2'd3, 32'h0, "ovr_race_ovr");

    // Held input and W1C race
    do_wr(2'd0, 32'hF);
    @(negedge clk);
    src = 4'h4;
    idle(20);
    src = 4'h0;
    do_rd(2'd0, 32'h4, "held_pend");
    do_rd(2'd3, 32'h0, "held_ovr");
    wr_with_src(2'd0, 32'h2, 4'h2);
    do_rd(2'd0, 32'h6, "w1c_race_pend");
    do_rd(2'd3, 32'h0, "w1c_race_ovr");

    // Async reset mid-sequence
    do_wr(2'd1, 32'hF);
    pulse(4'hF);
    idle(2);
    check("pre_rst_irq", 32'(irq_out), 32'd1);
    do_rd(2'd0, 32'hF, "pre_rst_pend");
    @(negedge clk);
    a = 2'd0; rd = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("arst_spo", spo, 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_irq", 32'(irq_out), 32'd0);
    rd = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("arst_no_ready", 32'(ready), 32'd0);
    do_rd(2'd0, 32'h0, "post_rst_pend");
    do_rd(2'd1, 32'h0, "post_rst_en");
    do_rd(2'd3, 32'h0, "post_rst_ovr");
    do_rd(2'd2, 32'h0, "post_rst_claim");
    idle(3);
    check("post_rst_irq", 32'(irq_out), 32'd0);
    check("queue_drained", 32'(q_cyc.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
